// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants and types for the time-multiplexed video RAM
//
// Purpose : geometry of the RAM, the four access phases of one CPU cycle,
//           and the latched-request record used by both access slots.
// Contents: ADDR_W, DATA_W, phase_e (PH_CPU_ADDR..PH_VID_DATA), req_t,
//           next_phase() helper.
package vram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // One CPU cycle is four clk periods. Each value names the phase that
  // follows the edge of the same number (E0 enters PH_CPU_ADDR, and so on).
  typedef enum logic [1:0] {
    PH_CPU_ADDR = 2'd0,
    PH_CPU_DATA = 2'd1,
    PH_VID_ADDR = 2'd2,
    PH_VID_DATA = 2'd3
  } phase_e;

  // A request captured at the start of its slot. valid is clear only
  // between reset and the first capture, so the reset-time contents of the
  // latch never touch the RAM or the output registers.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  function automatic phase_e next_phase(input phase_e p);
    logic [1:0] n;
    n = p + 2'd1;
    return phase_e'(n);
  endfunction

endpackage

// File: rtl/vram_if.sv
// rtl/vram_if.sv - CPU and video request/response bundle of the video RAM
//
// Purpose : groups both access ports of vram so they travel as one port.
// Signals : cpu_addr / cpu_write_enable / cpu_data_in       requester -> RAM
//           cpu_data_out                                    RAM -> requester
//           vram_addr / vram_write_enable / vram_data_in    requester -> RAM
//           vram_data_out / vram_input_valid /
//           vram_data_out_valid                             RAM -> requester
// Modports: master (CPU and video requesters), slave (vram).
interface vram_if;
  import vram_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_write_enable;
  logic [DATA_W-1:0] cpu_data_in;
  logic [DATA_W-1:0] cpu_data_out;

  logic [ADDR_W-1:0] vram_addr;
  logic              vram_write_enable;
  logic [DATA_W-1:0] vram_data_in;
  logic [DATA_W-1:0] vram_data_out;
  logic              vram_input_valid;
  logic              vram_data_out_valid;

  modport master (
    output cpu_addr, cpu_write_enable, cpu_data_in,
    output vram_addr, vram_write_enable, vram_data_in,
    input  cpu_data_out,
    input  vram_data_out, vram_input_valid, vram_data_out_valid
  );

  modport slave (
    input  cpu_addr, cpu_write_enable, cpu_data_in,
    input  vram_addr, vram_write_enable, vram_data_in,
    output cpu_data_out,
    output vram_data_out, vram_input_valid, vram_data_out_valid
  );

endinterface

// File: rtl/vram_bram.sv
// rtl/vram_bram.sv - 64 KiB x 8 single-port synchronous RAM
//
// Purpose : storage array shared by the CPU and video slots; written so it
//           maps onto block RAM (one port, registered read, no reset).
// Ports   : clk     in   clock
//           addr_i  in   ADDR_W  address
//           we_i    in   1       write enable
//           din_i   in   DATA_W  write data
//           dout_o  out  DATA_W  read data, registered (read-first)
module vram_bram
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];

  // No reset on purpose: a reset port would stop the array mapping onto
  // block RAM, and the contents are defined to survive reset anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
    dout_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/vram.sv
// rtl/vram.sv - video RAM time-multiplexed between a CPU port and a video port
//
// Purpose : one single-port RAM serves two requesters without stalls. A
//           phase counter splits every CPU cycle (4 clk) into a CPU slot
//           (phases 0-1) and a video slot (phases 2-3); cpu_clk is derived
//           from the same counter so the CPU always lines up with its slot.
// Ports   : clk      in   system clock, rising edge
//           reset_n  in   asynchronous active-low reset
//           cpu_clk  out  clk/4, high in phases 0 and 1, registered
//           bus      vram_if.slave: CPU and video requests and responses
//
// Slot timing (Ek = edge entering phase k):
//   E0  latch CPU request; finish video read (data + valid strobe)
//   E1  CPU write lands / CPU read launched in the RAM
//   E2  capture CPU read data; latch video request (input_valid strobe)
//   E3  video write lands / video read launched in the RAM
module vram
  import vram_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  output logic  cpu_clk,
  vram_if.slave bus
);

  phase_e            ph_q, ph_d;
  logic              cpu_clk_q, cpu_clk_d;
  req_t              cpu_req_q, cpu_req_d;
  req_t              vid_req_q, vid_req_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0] vid_dout_q, vid_dout_d;
  logic              vid_in_valid_q, vid_in_valid_d;
  logic              vid_out_valid_q, vid_out_valid_d;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // RAM port mux. The CPU request owns the array in phases 0-1 and the
  // video request in phases 2-3; writes are only enabled in the first phase
  // of each slot, so the second phase is a harmless read of the same
  // address while the previous read result is being captured.
  always_comb begin
    ram_addr = vid_req_q.addr;
    ram_din  = vid_req_q.data;
    ram_we   = 1'b0;
    unique case (ph_q)
      PH_CPU_ADDR: begin
        ram_addr = cpu_req_q.addr;
        ram_din  = cpu_req_q.data;
        ram_we   = cpu_req_q.valid && cpu_req_q.we;
      end
      PH_CPU_DATA: begin
        ram_addr = cpu_req_q.addr;
        ram_din  = cpu_req_q.data;
      end
      PH_VID_ADDR: begin
        ram_we   = vid_req_q.valid && vid_req_q.we;
      end
      PH_VID_DATA: begin
        ram_we   = 1'b0;
      end
      default: begin
        ram_we   = 1'b0;
      end
    endcase
  end

  vram_bram u_bram (
    .clk    (clk),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .din_i  (ram_din),
    .dout_o (ram_dout)
  );

  // Next-state logic. Decisions are keyed on the current phase, i.e. on
  // the edge that is about to happen: ph_q == PH_VID_DATA means "next edge
  // is E0", ph_q == PH_CPU_DATA means "next edge is E2".
  always_comb begin
    ph_d            = next_phase(ph_q);
    cpu_clk_d       = (ph_d == PH_CPU_ADDR) || (ph_d == PH_CPU_DATA);
    cpu_req_d       = cpu_req_q;
    vid_req_d       = vid_req_q;
    cpu_dout_d      = cpu_dout_q;
    vid_dout_d      = vid_dout_q;
    vid_in_valid_d  = 1'b0;
    vid_out_valid_d = 1'b0;

    unique case (ph_q)
      PH_VID_DATA: begin
        // E0: new CPU cycle starts; video read launched at E3 completes.
        cpu_req_d.valid = 1'b1;
        cpu_req_d.we    = bus.cpu_write_enable;
        cpu_req_d.addr  = bus.cpu_addr;
        cpu_req_d.data  = bus.cpu_data_in;
        if (vid_req_q.valid && !vid_req_q.we) begin
          vid_dout_d      = ram_dout;
          vid_out_valid_d = 1'b1;
        end
      end
      PH_CPU_DATA: begin
        // E2: video slot starts; CPU read launched at E1 completes.
        // Video requests are taken every slot, changed or not.
        vid_req_d.valid = 1'b1;
        vid_req_d.we    = bus.vram_write_enable;
        vid_req_d.addr  = bus.vram_addr;
        vid_req_d.data  = bus.vram_data_in;
        vid_in_valid_d  = 1'b1;
        if (cpu_req_q.valid && !cpu_req_q.we) begin
          cpu_dout_d = ram_dout;
        end
      end
      PH_CPU_ADDR: begin
        vid_in_valid_d  = 1'b0;
      end
      PH_VID_ADDR: begin
        vid_out_valid_d = 1'b0;
      end
      default: begin
        vid_in_valid_d  = 1'b0;
      end
    endcase
  end

  // Reset clears the request latches, so a write caught between its latch
  // edge and its commit edge is dropped (ram_we falls with valid/we).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q            <= PH_CPU_ADDR;
      cpu_clk_q       <= 1'b1;
      cpu_req_q       <= '0;
      vid_req_q       <= '0;
      cpu_dout_q      <= '0;
      vid_dout_q      <= '0;
      vid_in_valid_q  <= 1'b0;
      vid_out_valid_q <= 1'b0;
    end else begin
      ph_q            <= ph_d;
      cpu_clk_q       <= cpu_clk_d;
      cpu_req_q       <= cpu_req_d;
      vid_req_q       <= vid_req_d;
      cpu_dout_q      <= cpu_dout_d;
      vid_dout_q      <= vid_dout_d;
      vid_in_valid_q  <= vid_in_valid_d;
      vid_out_valid_q <= vid_out_valid_d;
    end
  end

  assign cpu_clk                 = cpu_clk_q;
  assign bus.cpu_data_out        = cpu_dout_q;
  assign bus.vram_data_out       = vid_dout_q;
  assign bus.vram_input_valid    = vid_in_valid_q;
  assign bus.vram_data_out_valid = vid_out_valid_q;

endmodule

// File: tb/tb_vram.sv
// tb/tb_vram.sv - self-checking bench for the time-multiplexed video RAM
//
// Purpose : drives CPU and video requests slot by slot from stimulus queues,
//           keeps a byte-level reference memory, and compares read results
//           and strobes against a scoreboard of expected values.
module tb_vram;
  import vram_pkg::*;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } op_t;

  typedef struct {
    logic       known;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_clk;
  logic [1:0] tb_ph = 2'd0;

  vram_if bus ();

  vram dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpu_clk (cpu_clk),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Independent phase reference: tb_ph is the phase the DUT should be in.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ph <= 2'd0;
    else          tb_ph <= tb_ph + 2'd1;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  op_t  cpu_stim[$];
  op_t  vid_stim[$];
  exp_t cpu_sb[$];
  exp_t vid_sb[$];
  exp_t cpu_last;
  exp_t vid_hold;
  logic [7:0] model [logic [15:0]];
  logic       started;
  logic [1:0] last_ph;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t lookup(input logic [15:0] a);
    exp_t e;
    e.known = (model.exists(a) != 0);
    e.data  = e.known ? model[a] : 8'h00;
    return e;
  endfunction

  function automatic op_t mk(input logic we, input logic [15:0] a, input logic [7:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    return o;
  endfunction

  // One clk period: check per-phase outputs at the falling edge, then drive
  // the CPU request before E0 (phase 3) and the video request before E2
  // (phase 1). Reference memory is updated in drive order, which is the
  // RAM's commit order (CPU at E1, video at E3).
  task automatic step();
    op_t  op;
    exp_t e;
    @(negedge clk);
    last_ph = tb_ph;
    check("cpu_clk", 16'(cpu_clk), 16'(tb_ph < 2'd2));
    check("vin_valid", 16'(bus.vram_input_valid), 16'(tb_ph == 2'd2));
    if (tb_ph == 2'd0) begin
      check("vout_valid", 16'(bus.vram_data_out_valid), 16'(vid_sb.size() > 0));
      if (vid_sb.size() > 0) vid_hold = vid_sb.pop_front();
    end else begin
      check("vout_valid", 16'(bus.vram_data_out_valid), 16'h0000);
    end
    if (vid_hold.known) check("vram_dout", 16'(bus.vram_data_out), 16'(vid_hold.data));

    if (tb_ph == 2'd3) begin
      e = cpu_sb.pop_front();
      if (e.known) check("cpu_dout", 16'(bus.cpu_data_out), 16'(e.data));
      if (cpu_stim.size() > 0) op = cpu_stim.pop_front();
      else                     op = mk(1'b0, 16'h0000, 8'h00);
      bus.cpu_addr         = op.addr;
      bus.cpu_write_enable = op.we;
      bus.cpu_data_in      = op.data;
      if (op.we) model[op.addr] = op.data;
      else       cpu_last = lookup(op.addr);
      cpu_sb.push_back(cpu_last);
      started = 1'b1;
    end

    if (tb_ph == 2'd1) begin
      if (started && vid_stim.size() > 0) op = vid_stim.pop_front();
      else                                op = mk(1'b0, 16'h0000, 8'h00);
      bus.vram_addr         = op.addr;
      bus.vram_write_enable = op.we;
      bus.vram_data_in      = op.data;
      if (op.we) model[op.addr] = op.data;
      else       vid_sb.push_back(lookup(op.addr));
    end
  endtask

  // Run until all stimulus is consumed and checked, ending right after a
  // phase-1 step so the next CPU and video entries share one CPU cycle.
  task automatic drain();
    while (cpu_stim.size() > 0 || vid_stim.size() > 0) step();
    repeat (12) step();
    while (last_ph != 2'd1) step();
  endtask

  task automatic clear_expect();
    exp_t z;
    z.known = 1'b1;
    z.data  = 8'h00;
    cpu_sb.delete();
    vid_sb.delete();
    cpu_sb.push_back(z);
    cpu_last = z;
    vid_hold = z;
    started  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_clk"}, 16'(cpu_clk), 16'h0001);
    check({tag, "_cpu_dout"}, 16'(bus.cpu_data_out), 16'h0000);
    check({tag, "_vram_dout"}, 16'(bus.vram_data_out), 16'h0000);
    check({tag, "_vin_valid"}, 16'(bus.vram_input_valid), 16'h0000);
    check({tag, "_vout_valid"}, 16'(bus.vram_data_out_valid), 16'h0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.cpu_addr          = 16'h0000;
    bus.cpu_write_enable  = 1'b0;
    bus.cpu_data_in       = 8'h00;
    bus.vram_addr         = 16'h0000;
    bus.vram_write_enable = 1'b0;
    bus.vram_data_in      = 8'h00;
    clear_expect();
    last_ph = 2'd0;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    reset_n = 1'b1;

    // Background values: idle slots read 0x0000; 0x0020 is used after reset.
    cpu_stim.push_back(mk(1'b1, 16'h0000, 8'h00));
    cpu_stim.push_back(mk(1'b1, 16'h0020, 8'h33));
    for (int r = 0; r < 8; r++) begin
      cpu_stim.push_back(mk(1'b1, 16'h1234, 8'hAB));
      cpu_stim.push_back(mk(1'b1, 16'hFFFF, 8'h32));
      cpu_stim.push_back(mk(1'b1, 16'h8000, 8'hAE));
      cpu_stim.push_back(mk(1'b0, 16'h1234, 8'h00));
      cpu_stim.push_back(mk(1'b0, 16'hFFFF, 8'h00));
      cpu_stim.push_back(mk(1'b0, 16'h8000, 8'h00));
    end
    for (int v = 0; v < 64; v++) begin
      vid_stim.push_back(mk(1'b1, 16'h4321, 8'hEA));
      vid_stim.push_back(mk(1'b1, 16'hFFFE, 8'h45));
      vid_stim.push_back(mk(1'b0, 16'h4321, 8'h00));
      vid_stim.push_back(mk(1'b0, 16'hFFFE, 8'h00));
    end
    drain();

    // Same-address writes in one CPU cycle: the video write lands last.
    cpu_stim.push_back(mk(1'b1, 16'h0100, 8'h11));
    vid_stim.push_back(mk(1'b1, 16'h0100, 8'h22));
    cpu_stim.push_back(mk(1'b0, 16'h0100, 8'h00));
    vid_stim.push_back(mk(1'b0, 16'h0100, 8'h00));
    drain();

    // Write at rise N, read-back sampled at rise N+1.
    cpu_stim.push_back(mk(1'b1, 16'h0010, 8'h5A));
    cpu_stim.push_back(mk(1'b0, 16'h0010, 8'h00));
    drain();

    // Mixed traffic on a small address window, conflicts included.
    for (int k = 0; k < 48; k++) begin
      cpu_stim.push_back(mk(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)),
                            8'($urandom)));
      vid_stim.push_back(mk(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)),
                            8'($urandom)));
    end
    drain();

    // Reset while a CPU write of 77@0x0020 is latched but not yet committed.
    cpu_stim.push_back(mk(1'b1, 16'h0020, 8'h77));
    while (cpu_stim.size() > 0) step();
    model[16'h0020] = 8'h33;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    repeat (3) begin
      @(negedge clk);
      check("rst1_hold_cpu_clk", 16'(cpu_clk), 16'h0001);
    end
    reset_n = 1'b1;
    clear_expect();
    cpu_stim.push_back(mk(1'b0, 16'h0020, 8'h00));
    vid_stim.push_back(mk(1'b0, 16'h0020, 8'h00));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
